// File: rtl/axis_packet_arbiter_pkg.sv
// Shared stream-arbitration types: FSM state encoding and the supported port ceiling.
`ifndef INPUTWIDTH
`define INPUTWIDTH 32
`endif

package eth_stream_pkg;

    localparam int ARB_MAX_PORTS = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/axis_packet_arbiter_if.sv
// AXI4-Stream bundle; master drives payload and tvalid, slave drives tready.
`ifndef INPUTWIDTH
`define INPUTWIDTH 32
`endif

interface axi_stream_if #(
    parameter int DATA_WIDTH = `INPUTWIDTH,
    parameter int USER_WIDTH = 1
);
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);

endinterface

// File: rtl/axis_packet_arbiter_rr.sv
// Combinational round-robin pick: first requester after last_grant_i, wrapping modulo NUM_PORTS.
module rr_priority_select
    import eth_stream_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int GW        = 1
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [GW-1:0]        last_grant_i,
    output logic                 any_req_o,
    output logic [GW-1:0]        sel_idx_o
);

    int          cand;
    logic [GW-1:0] cand_idx;
    logic        found;

    assign any_req_o = |req_i;

    // Fixed-bound scan so the loop unrolls identically for every legal NUM_PORTS.
    always_comb begin
        sel_idx_o = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= ARB_MAX_PORTS; k++) begin
            cand     = (int'(last_grant_i) + k) % NUM_PORTS;
            cand_idx = GW'(cand);
            if (k <= NUM_PORTS && !found && req_i[cand_idx]) begin
                sel_idx_o = cand_idx;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-locked round-robin arbiter: a granted requester owns m_axis until its tlast handshake.
`ifndef INPUTWIDTH
`define INPUTWIDTH 32
`endif

module axis_packet_arbiter
    import eth_stream_pkg::*;
#(
    parameter int  NUM_PORTS  = 2,
    parameter int  DATA_WIDTH = `INPUTWIDTH,
    parameter int  USER_WIDTH = 1,
    localparam int KEEP_WIDTH = DATA_WIDTH / 8,
    localparam int GW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    axi_stream_if.slave   s_axis [NUM_PORTS],
    axi_stream_if.master  m_axis,
    output logic          grant_valid,
    output logic [GW-1:0] grant_idx,
    output logic [15:0]   pkt_count
);

    arb_state_t      state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [15:0]     pkt_count_q, pkt_count_d;

    logic [NUM_PORTS-1:0]  req;
    logic [NUM_PORTS-1:0]  in_tlast;
    logic [DATA_WIDTH-1:0] in_tdata [NUM_PORTS];
    logic [KEEP_WIDTH-1:0] in_tkeep [NUM_PORTS];
    logic [USER_WIDTH-1:0] in_tuser [NUM_PORTS];

    logic          any_req;
    logic [GW-1:0] sel_idx;
    logic          locked;
    logic          last_beat;

    assign locked = (state_q == LOCKED);

    // Flatten the interface array so the datapath can be indexed by the registered grant.
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        assign req[g]             = s_axis[g].tvalid;
        assign in_tlast[g]        = s_axis[g].tlast;
        assign in_tdata[g]        = s_axis[g].tdata;
        assign in_tkeep[g]        = s_axis[g].tkeep;
        assign in_tuser[g]        = s_axis[g].tuser;
        assign s_axis[g].tready   = locked && (grant_q == GW'(g)) && m_axis.tready;
    end

    rr_priority_select #(
        .NUM_PORTS (NUM_PORTS),
        .GW        (GW)
    ) u_rr (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .any_req_o    (any_req),
        .sel_idx_o    (sel_idx)
    );

    assign m_axis.tvalid = locked && req[grant_q];
    assign m_axis.tdata  = in_tdata[grant_q];
    assign m_axis.tkeep  = in_tkeep[grant_q];
    assign m_axis.tuser  = in_tuser[grant_q];
    assign m_axis.tlast  = in_tlast[grant_q];

    assign last_beat = locked && req[grant_q] && m_axis.tready && in_tlast[grant_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_PORTS - 1);
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    // Arbitration only happens from IDLE, which forces one bubble cycle between packets.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        pkt_count_d  = pkt_count_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = sel_idx;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (last_beat) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                    pkt_count_d  = pkt_count_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_valid = locked;
    assign grant_idx   = grant_q;
    assign pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Bench for axis_packet_arbiter: directed scenarios plus randomized traffic against a packet-level model.
module tb_axis_packet_arbiter;

    localparam int NP = 2;
    localparam int DW = 32;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        mReady = 1'b1;
    logic        grant_valid;
    logic [0:0]  grant_idx;
    logic [15:0] pkt_count;
    bit          gap0, gap1;

    int          total = 0;
    int          bad   = 0;

    // Reference model: which port owns the output, who owned it last, packets delivered.
    int          owner = -1;
    int          lastG = NP - 1;
    logic [15:0] cnt   = '0;

    logic [DW:0] q0[$];
    logic [DW:0] q1[$];

    always #5 clk = ~clk;

    axi_stream_if #(.DATA_WIDTH(DW), .USER_WIDTH(1)) s_if [NP] ();
    axi_stream_if #(.DATA_WIDTH(DW), .USER_WIDTH(1)) m_if ();

    axis_packet_arbiter #(
        .NUM_PORTS  (NP),
        .DATA_WIDTH (DW),
        .USER_WIDTH (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .pkt_count   (pkt_count)
    );

    function automatic bit validNow(int p);
        if (p == 0) return (q0.size() != 0) && !gap0;
        return (q1.size() != 0) && !gap1;
    endfunction

    function automatic logic [DW:0] qFront(int p);
        if (p == 0) return q0[0];
        return q1[0];
    endfunction

    task automatic pushPacket(int p, int len, logic [DW-1:0] base);
        for (int i = 0; i < len; i++) begin
            logic [DW:0] beat;
            beat = {(i == len - 1), base + DW'(i)};
            if (p == 0) q0.push_back(beat);
            else        q1.push_back(beat);
        end
    endtask

    // Present the head of each source queue, then let combinational outputs settle.
    task automatic settle();
        logic [DW:0] b0, b1;
        b0 = (q0.size() != 0) ? q0[0] : '0;
        b1 = (q1.size() != 0) ? q1[0] : '0;
        s_if[0].tvalid = validNow(0);
        s_if[0].tdata  = b0[DW-1:0];
        s_if[0].tlast  = b0[DW];
        s_if[1].tvalid = validNow(1);
        s_if[1].tdata  = b1[DW-1:0];
        s_if[1].tlast  = b1[DW];
        m_if.tready    = mReady;
        #2;
    endtask

    // Clock edge plus model update: grant to first valid port after lastG, release on tlast.
    task automatic advance();
        bit          v [NP];
        bit          hs;
        logic [DW:0] b;
        for (int p = 0; p < NP; p++) v[p] = validNow(p);
        hs = (owner >= 0) && v[owner] && mReady;
        b  = hs ? qFront(owner) : '0;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            owner = -1;
            lastG = NP - 1;
            cnt   = '0;
        end else if (owner < 0) begin
            for (int k = 1; k <= NP; k++) begin
                int p;
                p = (lastG + k) % NP;
                if (owner < 0 && v[p]) owner = p;
            end
        end else if (hs) begin
            if (owner == 0) void'(q0.pop_front());
            else            void'(q1.pop_front());
            if (b[DW]) begin
                lastG = owner;
                owner = -1;
                cnt   = cnt + 16'd1;
            end
        end
    endtask

    task automatic doReset();
        rst_n  = 1'b0;
        q0.delete();
        q1.delete();
        gap0   = 1'b0;
        gap1   = 1'b0;
        mReady = 1'b1;
        settle(); advance();
        settle(); advance();
        rst_n  = 1'b1;
    endtask

    task automatic test_reset();
        doReset();
        settle();
        total++; if (grant_valid !== 1'b0)  begin bad++; $display("[TB] FAIL reset_gv got=%0b exp=0", grant_valid); end
        total++; if (grant_idx !== 1'b0)    begin bad++; $display("[TB] FAIL reset_idx got=%0d exp=0", grant_idx); end
        total++; if (pkt_count !== 16'd0)   begin bad++; $display("[TB] FAIL reset_cnt got=%0d exp=0", pkt_count); end
        total++; if (m_if.tvalid !== 1'b0)  begin bad++; $display("[TB] FAIL reset_mvalid got=%0b exp=0", m_if.tvalid); end
        total++; if ((s_if[0].tready | s_if[1].tready) !== 1'b0)
            begin bad++; $display("[TB] FAIL reset_tready got=%0b%0b exp=00", s_if[1].tready, s_if[0].tready); end
        advance();
    endtask

    task automatic test_simultaneous();
        int          expGv [9]  = '{0, 1, 1, 1, 0, 1, 1, 1, 0};
        int          expIdx [9] = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
        logic [31:0] beats[$];
        logic [31:0] want;
        doReset();
        pushPacket(0, 3, 32'h100);
        pushPacket(1, 3, 32'h200);
        for (int c = 0; c < 9; c++) begin
            settle();
            total++; if (grant_valid !== expGv[c][0])
                begin bad++; $display("[TB] FAIL sim_gv c=%0d got=%0b exp=%0b", c, grant_valid, expGv[c][0]); end
            total++; if (grant_idx !== expIdx[c][0])
                begin bad++; $display("[TB] FAIL sim_idx c=%0d got=%0d exp=%0d", c, grant_idx, expIdx[c]); end
            if (m_if.tvalid && m_if.tready) beats.push_back(m_if.tdata);
            advance();
        end
        total++; if (beats.size() != 6) begin bad++; $display("[TB] FAIL sim_nbeats got=%0d exp=6", beats.size()); end
        for (int i = 0; i < 6 && i < beats.size(); i++) begin
            want = (i < 3) ? 32'h100 + 32'(i) : 32'h200 + 32'(i - 3);
            total++; if (beats[i] !== want) begin bad++; $display("[TB] FAIL sim_beat%0d got=%0h exp=%0h", i, beats[i], want); end
        end
        total++; if (pkt_count !== 16'd2) begin bad++; $display("[TB] FAIL sim_cnt got=%0d exp=2", pkt_count); end
    endtask

    task automatic test_alternate();
        int          grants[$];
        bit          prevGv  = 1'b0;
        int          c       = 0;
        logic [15:0] prevCnt;
        doReset();
        prevCnt = cnt;
        pushPacket(1, 2, 32'h300);
        pushPacket(1, 2, 32'h310);
        pushPacket(1, 2, 32'h320);
        while (grants.size() < 6 && c < 200) begin
            settle();
            if (grant_valid && !prevGv) grants.push_back(int'(grant_idx));
            prevGv = grant_valid;
            advance();
            c++;
            if (cnt != prevCnt) begin
                prevCnt = cnt;
                if (lastG == 1) pushPacket(0, 2, 32'h400 + 32'(c));
            end
        end
        total++; if (grants.size() != 6) begin bad++; $display("[TB] FAIL alt_ngrants got=%0d exp=6", grants.size()); end
        for (int i = 0; i < grants.size(); i++) begin
            total++; if (grants[i] != ((i % 2 == 0) ? 1 : 0))
                begin bad++; $display("[TB] FAIL alt_grant%0d got=%0d exp=%0d", i, grants[i], (i % 2 == 0) ? 1 : 0); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] beats[$];
        doReset();
        pushPacket(0, 4, 32'h500);
        mReady = 1'b0;
        for (int c = 0; c < 12; c++) begin
            settle();
            if (grant_valid) begin
                total++; if (s_if[0].tready !== mReady)
                    begin bad++; $display("[TB] FAIL bp_mirror c=%0d got=%0b exp=%0b", c, s_if[0].tready, mReady); end
                total++; if (s_if[1].tready !== 1'b0)
                    begin bad++; $display("[TB] FAIL bp_other c=%0d got=%0b exp=0", c, s_if[1].tready); end
            end
            if (m_if.tvalid && m_if.tready) beats.push_back(m_if.tdata);
            advance();
            mReady = ~mReady;
        end
        mReady = 1'b1;
        total++; if (beats.size() != 4) begin bad++; $display("[TB] FAIL bp_nbeats got=%0d exp=4", beats.size()); end
        for (int i = 0; i < 4 && i < beats.size(); i++) begin
            total++; if (beats[i] !== 32'h500 + 32'(i))
                begin bad++; $display("[TB] FAIL bp_beat%0d got=%0h exp=%0h", i, beats[i], 32'h500 + 32'(i)); end
        end
        total++; if (pkt_count !== 16'd1) begin bad++; $display("[TB] FAIL bp_cnt got=%0d exp=1", pkt_count); end
    endtask

    task automatic test_valid_drop();
        int first = -1;
        doReset();
        pushPacket(0, 5, 32'h600);
        pushPacket(1, 2, 32'h610);
        for (int c = 0; c < 12; c++) begin
            gap0 = (c == 3 || c == 4);
            settle();
            if (c >= 1 && c <= 7) begin
                total++; if (grant_valid !== 1'b1) begin bad++; $display("[TB] FAIL drop_gv c=%0d got=%0b exp=1", c, grant_valid); end
                total++; if (grant_idx !== 1'b0) begin bad++; $display("[TB] FAIL drop_idx c=%0d got=%0d exp=0", c, grant_idx); end
                total++; if (s_if[1].tready !== 1'b0)
                    begin bad++; $display("[TB] FAIL drop_p1ready c=%0d got=%0b exp=0", c, s_if[1].tready); end
            end
            if (c == 3 || c == 4) begin
                total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("[TB] FAIL drop_mvalid c=%0d got=%0b exp=0", c, m_if.tvalid); end
            end
            if (first < 0 && grant_valid && grant_idx == 1'b1) first = c;
            advance();
        end
        gap0 = 1'b0;
        total++; if (first != 9) begin bad++; $display("[TB] FAIL drop_p1start got=%0d exp=9", first); end
    endtask

    task automatic test_reset_mid();
        mReady = 1'b1;
        pushPacket(0, 1, 32'h700);
        for (int c = 0; c < 3; c++) begin settle(); advance(); end
        pushPacket(1, 5, 32'h800);
        for (int c = 0; c < 3; c++) begin
            if (c == 2) rst_n = 1'b0;
            settle();
            advance();
        end
        rst_n = 1'b1;
        q0.delete();
        q1.delete();
        pushPacket(0, 2, 32'h900);
        pushPacket(1, 2, 32'hA00);
        settle();
        total++; if (grant_valid !== 1'b0) begin bad++; $display("[TB] FAIL rmid_gv got=%0b exp=0", grant_valid); end
        total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("[TB] FAIL rmid_mvalid got=%0b exp=0", m_if.tvalid); end
        total++; if (pkt_count !== 16'd0)  begin bad++; $display("[TB] FAIL rmid_cnt got=%0d exp=0", pkt_count); end
        total++; if (s_if[1].tready !== 1'b0) begin bad++; $display("[TB] FAIL rmid_p1ready got=%0b exp=0", s_if[1].tready); end
        advance();
        settle();
        total++; if (grant_valid !== 1'b1) begin bad++; $display("[TB] FAIL rmid_regrant_gv got=%0b exp=1", grant_valid); end
        total++; if (grant_idx !== 1'b0)   begin bad++; $display("[TB] FAIL rmid_regrant_idx got=%0d exp=0", grant_idx); end
        advance();
    endtask

    task automatic test_pkt_wrap();
        logic [15:0] expCnt [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
        doReset();
        force dut.pkt_count_q = 16'hFFFD;
        #1;
        release dut.pkt_count_q;
        cnt = 16'hFFFD;
        for (int n = 0; n < 3; n++) begin
            pushPacket(n % 2, 1, 32'hB00 + 32'(n));
            for (int c = 0; c < 2; c++) begin settle(); advance(); end
            total++; if (pkt_count !== expCnt[n])
                begin bad++; $display("[TB] FAIL wrap_cnt%0d got=%0h exp=%0h", n, pkt_count, expCnt[n]); end
        end
    endtask

    task automatic test_random();
        bit          expV;
        logic        ownRdy, othRdy;
        logic [DW:0] b;
        doReset();
        for (int c = 0; c < 600; c++) begin
            if (q0.size() < 6 && $urandom_range(0, 3) == 0) pushPacket(0, int'($urandom_range(1, 4)), $urandom);
            if (q1.size() < 6 && $urandom_range(0, 3) == 0) pushPacket(1, int'($urandom_range(1, 4)), $urandom);
            gap0   = ($urandom_range(0, 9) == 0);
            gap1   = ($urandom_range(0, 9) == 0);
            mReady = ($urandom_range(0, 3) != 0);
            settle();
            total++; if (grant_valid !== (owner >= 0))
                begin bad++; $display("[TB] FAIL rnd_gv c=%0d got=%0b exp=%0b", c, grant_valid, owner >= 0); end
            total++; if (pkt_count !== cnt)
                begin bad++; $display("[TB] FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, pkt_count, cnt); end
            if (owner >= 0) begin
                expV   = validNow(owner);
                ownRdy = (owner == 0) ? s_if[0].tready : s_if[1].tready;
                othRdy = (owner == 0) ? s_if[1].tready : s_if[0].tready;
                total++; if (grant_idx !== 1'(owner))
                    begin bad++; $display("[TB] FAIL rnd_idx c=%0d got=%0d exp=%0d", c, grant_idx, owner); end
                total++; if (m_if.tvalid !== expV)
                    begin bad++; $display("[TB] FAIL rnd_mvalid c=%0d got=%0b exp=%0b", c, m_if.tvalid, expV); end
                total++; if (ownRdy !== mReady || othRdy !== 1'b0)
                    begin bad++; $display("[TB] FAIL rnd_tready c=%0d got=%0b/%0b exp=%0b/0", c, ownRdy, othRdy, mReady); end
                if (expV) begin
                    b = qFront(owner);
                    total++; if (m_if.tdata !== b[DW-1:0] || m_if.tlast !== b[DW])
                        begin bad++; $display("[TB] FAIL rnd_beat c=%0d got=%0h/%0b exp=%0h/%0b", c, m_if.tdata, m_if.tlast, b[DW-1:0], b[DW]); end
                    total++; if (m_if.tuser !== 1'(owner) || m_if.tkeep !== 4'hF)
                        begin bad++; $display("[TB] FAIL rnd_side c=%0d got=%0b/%0h exp=%0d/f", c, m_if.tuser, m_if.tkeep, owner); end
                end
            end else begin
                total++; if (m_if.tvalid !== 1'b0 || (s_if[0].tready | s_if[1].tready) !== 1'b0)
                    begin bad++; $display("[TB] FAIL rnd_idle c=%0d got=%0b/%0b%0b exp=0/00", c, m_if.tvalid, s_if[1].tready, s_if[0].tready); end
            end
            advance();
        end
    endtask

    initial begin
        s_if[0].tkeep = '1;
        s_if[1].tkeep = '1;
        s_if[0].tuser = 1'b0;
        s_if[1].tuser = 1'b1;
        $display("[TB] starting axis_packet_arbiter bench");
        test_reset();
        test_simultaneous();
        test_alternate();
        test_backpressure();
        test_valid_drop();
        test_reset_mid();
        test_pkt_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
